ctrl_sequencer: RTL and testbench

Microcode sequencer for the 8-bit bus CPU. It holds the T-state step counter and the halt latch. Each step it decodes the 4-bit opcode from the instruction register, plus the carry/zero flags, into the per-block load/enable strobes that drive the register file, ALU, RAM, PC and output register. It sits directly upstream of every bus register: its `o_*i` outputs feed their `i_load` pins and its `o_*o` outputs feed their `i_enable` pins.

---
 rtl/ctrl_pkg.sv | 60 ++++++
 rtl/ctrl_sequencer_if.sv | 15 +
 rtl/ctrl_microcode.sv | 50 +++++
 rtl/ctrl_sequencer.sv | 128 ++++++++++++
 tb/tb_ctrl_sequencer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, control-word layout and FSM state type for the sequencer
// Purpose: opcode encodings, control-word bit indices and one-hot masks,
//          the 16-bit control-word type and the sequencer state enum.
package ctrl_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef logic [15:0] cw_t;

    localparam int CW_HLT_BIT = 15;
    localparam int CW_MI_BIT  = 14;
    localparam int CW_RI_BIT  = 13;
    localparam int CW_RO_BIT  = 12;
    localparam int CW_IO_BIT  = 11;
    localparam int CW_II_BIT  = 10;
    localparam int CW_AI_BIT  = 9;
    localparam int CW_AO_BIT  = 8;
    localparam int CW_EO_BIT  = 7;
    localparam int CW_SU_BIT  = 6;
    localparam int CW_BI_BIT  = 5;
    localparam int CW_OI_BIT  = 4;
    localparam int CW_CE_BIT  = 3;
    localparam int CW_CO_BIT  = 2;
    localparam int CW_J_BIT   = 1;
    localparam int CW_FI_BIT  = 0;

    localparam cw_t CW_NONE = 16'h0000;
    localparam cw_t CW_HLT  = cw_t'(1) << CW_HLT_BIT;
    localparam cw_t CW_MI   = cw_t'(1) << CW_MI_BIT;
    localparam cw_t CW_RI   = cw_t'(1) << CW_RI_BIT;
    localparam cw_t CW_RO   = cw_t'(1) << CW_RO_BIT;
    localparam cw_t CW_IO   = cw_t'(1) << CW_IO_BIT;
    localparam cw_t CW_II   = cw_t'(1) << CW_II_BIT;
    localparam cw_t CW_AI   = cw_t'(1) << CW_AI_BIT;
    localparam cw_t CW_AO   = cw_t'(1) << CW_AO_BIT;
    localparam cw_t CW_EO   = cw_t'(1) << CW_EO_BIT;
    localparam cw_t CW_SU   = cw_t'(1) << CW_SU_BIT;
    localparam cw_t CW_BI   = cw_t'(1) << CW_BI_BIT;
    localparam cw_t CW_OI   = cw_t'(1) << CW_OI_BIT;
    localparam cw_t CW_CE   = cw_t'(1) << CW_CE_BIT;
    localparam cw_t CW_CO   = cw_t'(1) << CW_CO_BIT;
    localparam cw_t CW_J    = cw_t'(1) << CW_J_BIT;
    localparam cw_t CW_FI   = cw_t'(1) << CW_FI_BIT;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } seq_state_e;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// rtl/ctrl_sequencer_if.sv - decode bundle between the step/halt logic and the microcode ROM
// Signals: opcode, flag_c, flag_z, step (sequencer -> decoder), cw (decoder -> sequencer).
// Modports: master = sequencer side, slave = microcode decoder side.
interface ctrl_sequencer_if;
    import ctrl_pkg::*;

    logic [3:0] opcode;
    logic       flag_c;
    logic       flag_z;
    logic [2:0] step;
    cw_t        cw;

    modport master (output opcode, output flag_c, output flag_z, output step, input cw);
    modport slave  (input opcode, input flag_c, input flag_z, input step, output cw);
endinterface

// File: rtl/ctrl_microcode.sv
// rtl/ctrl_microcode.sv - combinational (opcode, step, flags) to control-word decoder
// Ports: bus (ctrl_sequencer_if.slave): opcode/flags/step in, cw out.
module ctrl_microcode
    import ctrl_pkg::*;
(
    ctrl_sequencer_if.slave bus
);

    cw_t word;

    always_comb begin
        word = CW_NONE;
        case (bus.step)
            3'd0: word = CW_CO | CW_MI;
            3'd1: word = CW_RO | CW_II | CW_CE;
            3'd2: begin
                case (bus.opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: word = CW_IO | CW_MI;
                    OP_LDI: word = CW_IO | CW_AI;
                    OP_JMP: word = CW_IO | CW_J;
                    // Flags are looked at live, so a flag change mid-step moves o_j at once.
                    OP_JC:  word = bus.flag_c ? (CW_IO | CW_J) : CW_NONE;
                    OP_JZ:  word = bus.flag_z ? (CW_IO | CW_J) : CW_NONE;
                    OP_OUT: word = CW_AO | CW_OI;
                    OP_HLT: word = CW_HLT;
                    default: word = CW_NONE;
                endcase
            end
            3'd3: begin
                case (bus.opcode)
                    OP_LDA:         word = CW_RO | CW_AI;
                    OP_ADD, OP_SUB: word = CW_RO | CW_BI;
                    OP_STA:         word = CW_AO | CW_RI;
                    default:        word = CW_NONE;
                endcase
            end
            3'd4: begin
                case (bus.opcode)
                    OP_ADD:  word = CW_EO | CW_AI | CW_FI;
                    OP_SUB:  word = CW_EO | CW_AI | CW_SU | CW_FI;
                    default: word = CW_NONE;
                endcase
            end
            default: word = CW_NONE;
        endcase
    end

    assign bus.cw = word;

endmodule

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - T-state counter, halt latch and control strobe outputs for the bus CPU
// Optional feature macro: CTRL_EARLY_RESET_EN (restart at T0 after the first empty step >= T2).
// Ports: i_clk (state moves on falling edge), i_rst (async, active low), i_opcode, i_flag_c,
//        i_flag_z; o_hlt; loads o_mi o_ri o_ii o_ai o_bi o_oi o_j o_fi; drivers o_co o_ro
//        o_io o_ao o_eo; o_ce, o_su; o_step (debug T-state).
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int STEPS = 5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_opcode,
    input  logic       i_flag_c,
    input  logic       i_flag_z,
    output logic       o_hlt,
    output logic       o_mi,
    output logic       o_ri,
    output logic       o_ii,
    output logic       o_ai,
    output logic       o_bi,
    output logic       o_oi,
    output logic       o_j,
    output logic       o_fi,
    output logic       o_co,
    output logic       o_ro,
    output logic       o_io,
    output logic       o_ao,
    output logic       o_eo,
    output logic       o_ce,
    output logic       o_su,
    output logic [2:0] o_step
);

    localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

    ctrl_sequencer_if u_bus ();

    seq_state_e state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [2:0] step_inc;
    logic       early_zero;
    cw_t        word;
    cw_t        out_w;

    assign u_bus.opcode = i_opcode;
    assign u_bus.flag_c = i_flag_c;
    assign u_bus.flag_z = i_flag_z;
    assign u_bus.step   = step_q;

    ctrl_microcode u_microcode (
        .bus (u_bus)
    );

    assign word     = u_bus.cw;
    assign step_inc = (step_q == LAST_STEP) ? 3'd0 : step_q + 3'd1;

`ifdef CTRL_EARLY_RESET_EN
    // Fetch steps are never empty, so only execute steps can end an instruction early.
    assign early_zero = (step_q >= 3'd2) && (word == CW_NONE);
`else
    assign early_zero = 1'b0;
`endif

    always_ff @(negedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_RUN;
            step_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            ST_RUN: begin
                // Step is frozen on the HLT step so the debug port shows where it stopped.
                if (word[CW_HLT_BIT]) begin
                    state_d = ST_HALTED;
                end else if (early_zero) begin
                    step_d = 3'd0;
                end else begin
                    step_d = step_inc;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
                step_d  = 3'd0;
            end
        endcase
    end

    // Reset gates outputs directly so strobes drop the instant reset asserts.
    always_comb begin
        out_w = word;
        if (!i_rst) begin
            out_w = CW_NONE;
        end else if (state_q == ST_HALTED) begin
            out_w = CW_HLT;
        end
    end

    assign o_step = i_rst ? step_q : 3'd0;

    assign o_hlt = out_w[CW_HLT_BIT];
    assign o_mi  = out_w[CW_MI_BIT];
    assign o_ri  = out_w[CW_RI_BIT];
    assign o_ii  = out_w[CW_II_BIT];
    assign o_ai  = out_w[CW_AI_BIT];
    assign o_bi  = out_w[CW_BI_BIT];
    assign o_oi  = out_w[CW_OI_BIT];
    assign o_j   = out_w[CW_J_BIT];
    assign o_fi  = out_w[CW_FI_BIT];
    assign o_co  = out_w[CW_CO_BIT];
    assign o_ro  = out_w[CW_RO_BIT];
    assign o_io  = out_w[CW_IO_BIT];
    assign o_ao  = out_w[CW_AO_BIT];
    assign o_eo  = out_w[CW_EO_BIT];
    assign o_ce  = out_w[CW_CE_BIT];
    assign o_su  = out_w[CW_SU_BIT];

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - self-checking bench for ctrl_sequencer (vector table, corner sequences, random vs model)
`timescale 1ns/1ps
module tb_ctrl_sequencer;

    localparam int STEPS = 5;
`ifdef CTRL_EARLY_RESET_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hlt, mi, ri, ii, ai, bi, oi, j, fi, co, ro, io, ao, eo, ce, su;

    int vectors = 0;
    int miscompares = 0;

    ctrl_sequencer_if tb_bus ();

    always #5 clk = ~clk;

    ctrl_sequencer #(.STEPS(STEPS)) dut (
        .i_clk    (clk),
        .i_rst    (rst_n),
        .i_opcode (tb_bus.opcode),
        .i_flag_c (tb_bus.flag_c),
        .i_flag_z (tb_bus.flag_z),
        .o_hlt    (hlt),
        .o_mi     (mi),
        .o_ri     (ri),
        .o_ii     (ii),
        .o_ai     (ai),
        .o_bi     (bi),
        .o_oi     (oi),
        .o_j      (j),
        .o_fi     (fi),
        .o_co     (co),
        .o_ro     (ro),
        .o_io     (io),
        .o_ao     (ao),
        .o_eo     (eo),
        .o_ce     (ce),
        .o_su     (su),
        .o_step   (tb_bus.step)
    );

    // Observed outputs packed in the order the ports are listed.
    assign tb_bus.cw = {hlt, mi, ri, ii, ai, bi, oi, j, fi, co, ro, io, ao, eo, ce, su};

    function automatic logic [15:0] name_bit(input string n);
        case (n)
            "hlt": return 16'h8000;
            "mi":  return 16'h4000;
            "ri":  return 16'h2000;
            "ii":  return 16'h1000;
            "ai":  return 16'h0800;
            "bi":  return 16'h0400;
            "oi":  return 16'h0200;
            "j":   return 16'h0100;
            "fi":  return 16'h0080;
            "co":  return 16'h0040;
            "ro":  return 16'h0020;
            "io":  return 16'h0010;
            "ao":  return 16'h0008;
            "eo":  return 16'h0004;
            "ce":  return 16'h0002;
            "su":  return 16'h0001;
            default: begin
                $display("bench: unknown strobe name %s", n);
                return 16'h0000;
            end
        endcase
    endfunction

    function automatic logic [15:0] mask_of(input string s);
        logic [15:0] m = 16'h0000;
        string tok = "";
        for (int i = 0; i <= s.len(); i++) begin
            if (i == s.len() || s[i] == " ") begin
                if (tok.len() > 0) m = m | name_bit(tok);
                tok = "";
            end else begin
                tok = {tok, s.substr(i, i)};
            end
        end
        return m;
    endfunction

    // Reference microprogram written as the operation table reads.
    function automatic string uops(input logic [3:0] op, input int t, input logic c, input logic z);
        if (t == 0) return "co mi";
        if (t == 1) return "ro ii ce";
        if (t == 2) begin
            case (op)
                4'd1, 4'd2, 4'd3, 4'd4: return "io mi";
                4'd5:  return "io ai";
                4'd6:  return "io j";
                4'd7:  return c ? "io j" : "";
                4'd8:  return z ? "io j" : "";
                4'd14: return "ao oi";
                4'd15: return "hlt";
                default: return "";
            endcase
        end
        if (t == 3) begin
            case (op)
                4'd1: return "ro ai";
                4'd2, 4'd3: return "ro bi";
                4'd4: return "ao ri";
                default: return "";
            endcase
        end
        if (t == 4) begin
            case (op)
                4'd2: return "eo ai fi";
                4'd3: return "eo ai su fi";
                default: return "";
            endcase
        end
        return "";
    endfunction

    task automatic check(input string name, input logic [15:0] ew, input logic [2:0] es);
        vectors++;
        if (tb_bus.cw !== ew || tb_bus.step !== es || $countones({co, ro, io, ao, eo}) > 1) begin
            miscompares++;
            $display("FAIL %s: got word=%04h step=%0d, required word=%04h step=%0d",
                     name, tb_bus.cw, tb_bus.step, ew, es);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_async", 16'h0000, 3'd0);
        rst_n = 1'b1;
        #1;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic        c;
        logic        z;
        logic [2:0]  step;
        logic [15:0] word;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int m_step;
        bit m_halt;
        logic [15:0] ew;

        tb_bus.opcode = 4'hF;
        tb_bus.flag_c = 1'b1;
        tb_bus.flag_z = 1'b1;

        // ADD walk, wrap, then untaken JC.
        tbl.push_back('{4'h2, 1'b0, 1'b0, 3'd0, mask_of("co mi")});
        tbl.push_back('{4'h2, 1'b0, 1'b0, 3'd1, mask_of("ro ii ce")});
        tbl.push_back('{4'h2, 1'b0, 1'b0, 3'd2, mask_of("io mi")});
        tbl.push_back('{4'h2, 1'b0, 1'b0, 3'd3, mask_of("ro bi")});
        tbl.push_back('{4'h2, 1'b0, 1'b0, 3'd4, mask_of("eo ai fi")});
        tbl.push_back('{4'h7, 1'b0, 1'b1, 3'd0, mask_of("co mi")});
        tbl.push_back('{4'h7, 1'b0, 1'b1, 3'd1, mask_of("ro ii ce")});
        tbl.push_back('{4'h7, 1'b0, 1'b1, 3'd2, mask_of("")});
`ifndef CTRL_EARLY_RESET_EN
        tbl.push_back('{4'h7, 1'b0, 1'b1, 3'd3, mask_of("")});
        tbl.push_back('{4'h7, 1'b0, 1'b1, 3'd4, mask_of("")});
`endif
        tbl.push_back('{4'h5, 1'b0, 1'b0, 3'd0, mask_of("co mi")});

        #3;
        check("reset_hold", 16'h0000, 3'd0);
        tb_bus.opcode = 4'h0;
        tb_bus.flag_c = 1'b0;
        tb_bus.flag_z = 1'b0;
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            tb_bus.opcode = tbl[i].op;
            tb_bus.flag_c = tbl[i].c;
            tb_bus.flag_z = tbl[i].z;
            #1;
            check($sformatf("tbl%0d", i), tbl[i].word, tbl[i].step);
            tick();
        end

        // JZ taken, flag drops mid-T2.
        do_reset();
        tb_bus.opcode = 4'h8;
        tb_bus.flag_z = 1'b1;
        tb_bus.flag_c = 1'b0;
        #1;
        check("jz_t0", mask_of("co mi"), 3'd0);
        tick();
        tick();
        check("jz_taken", mask_of("io j"), 3'd2);
        tb_bus.flag_z = 1'b0;
        #1;
        check("jz_flag_drop", 16'h0000, 3'd2);
        tb_bus.flag_z = 1'b1;
        #1;
        check("jz_flag_back", mask_of("io j"), 3'd2);

        // HLT latches and freezes the step.
        do_reset();
        tb_bus.opcode = 4'hF;
        tick();
        tick();
        check("hlt_t2", mask_of("hlt"), 3'd2);
        for (int k = 0; k < 10; k++) begin
            tick();
            tb_bus.opcode = 4'($urandom_range(15));
            #1;
            check("halted", mask_of("hlt"), 3'd2);
        end
        do_reset();
        tb_bus.opcode = 4'hF;
        #1;
        check("hlt_exit", mask_of("co mi"), 3'd0);

        // Reset in SUB T3.
        tick();
        do_reset();
        tb_bus.opcode = 4'h3;
        tick();
        tick();
        tick();
        check("sub_t3", mask_of("ro bi"), 3'd3);
        do_reset();
        check("sub_abort", mask_of("co mi"), 3'd0);

        // Random stimulus against the reference model.
        tick();
        do_reset();
        m_step = 0;
        m_halt = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            tb_bus.opcode = 4'($urandom_range(15));
            tb_bus.flag_c = 1'($urandom_range(1));
            tb_bus.flag_z = 1'($urandom_range(1));
            #1;
            ew = m_halt ? mask_of("hlt")
                        : mask_of(uops(tb_bus.opcode, m_step, tb_bus.flag_c, tb_bus.flag_z));
            check("rand", ew, 3'(m_step));
            if ($urandom_range(24) == 0) begin
                do_reset();
                m_step = 0;
                m_halt = 1'b0;
            end else begin
                @(negedge clk);
                if (!m_halt) begin
                    if (ew[15]) m_halt = 1'b1;
                    else if (EARLY && m_step >= 2 && ew == 16'h0000) m_step = 0;
                    else m_step = (m_step + 1) % STEPS;
                end
                #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
